weight_mem_arbiter: RTL and testbench

Sequencer and arbiter for the single-port byte-wide perceptron weight memory. After reset it zero-fills every weight byte. It then shares the memory between two requesters:
- Port A: predictor/trainer, high priority.
- Port B: host/debug readback and preload, low priority, with a starvation guard.
It owns all memory timing (address setup, write-enable hold, latch close), so requesters see a simple req/gnt/done handshake.

---
 rtl/weight_mem_arbiter_if.sv | 28 ++
 rtl/weight_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_weight_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/weight_mem_arbiter_if.sv
// weight_mem_arbiter_if: requester handshakes and memory bus of the weight memory arbiter
interface weight_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  a_req, a_we, a_gnt, a_done;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [7:0]            a_wdata;
    logic                  b_req, b_we, b_gnt, b_done;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [7:0]            b_wdata;
    logic [7:0]            rdata;
    logic                  err, clear_done, busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [7:0]            mem_wdata, mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
        output a_gnt, a_done, b_gnt, b_done, rdata, err, clear_done, busy,
               mem_addr, mem_wr_en, mem_wdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
        input  a_gnt, a_done, b_gnt, b_done, rdata, err, clear_done, busy,
               mem_addr, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/weight_mem_arbiter.sv
// weight_mem_arbiter: zero-fills the weight memory, then arbitrates it between ports A and B
module weight_mem_arbiter #(
    parameter int ADDR_WIDTH   = 7,
    parameter int STORAGE_B    = 96,
    parameter int WR_CYCLES    = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst_n,
    weight_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(STORAGE_B - 1);
    localparam logic [ADDR_WIDTH:0]   LIMIT  = (ADDR_WIDTH + 1)'(STORAGE_B);
    localparam logic [1:0]            WLAST  = 2'(WR_CYCLES - 1);
    localparam logic [SW-1:0]         STARVE = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {CLEAR_WR, CLEAR_CLOSE, IDLE, RD_ADDR, RD_CAP, WR, WR_CLOSE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [1:0]            wcnt;
    logic [SW-1:0]         starve_cnt;
    logic                  cur_b, cur_err;
    logic                  pick_a, pick_b, sel_we, sel_err;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_wdata;

    // Pick the IDLE winner: A has priority unless B has waited through STARVE_LIMIT A grants
    always_comb begin
        pick_b    = bus.b_req && (!bus.a_req || starve_cnt == STARVE);
        pick_a    = bus.a_req && !pick_b;
        sel_we    = pick_b ? bus.b_we : bus.a_we;
        sel_addr  = pick_b ? bus.b_addr : bus.a_addr;
        sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
        sel_err   = {1'b0, sel_addr} >= LIMIT;
    end

    // Sequencer: every output is registered at the transition into the state that owns it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= CLEAR_WR;
            clr_addr       <= '0;
            wcnt           <= '0;
            starve_cnt     <= '0;
            cur_b          <= 1'b0;
            cur_err        <= 1'b0;
            bus.a_gnt      <= 1'b0;
            bus.a_done     <= 1'b0;
            bus.b_gnt      <= 1'b0;
            bus.b_done     <= 1'b0;
            bus.rdata      <= '0;
            bus.err        <= 1'b0;
            bus.clear_done <= 1'b0;
            bus.busy       <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wr_en  <= 1'b0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.a_gnt  <= 1'b0;
            bus.b_gnt  <= 1'b0;
            bus.a_done <= 1'b0;
            bus.b_done <= 1'b0;
            bus.err    <= 1'b0;
            case (state)
                CLEAR_WR: begin
                    if (!bus.mem_wr_en) begin
                        bus.mem_wr_en <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.mem_addr  <= clr_addr;
                        bus.mem_wdata <= '0;
                    end else if (wcnt == WLAST) begin
                        bus.mem_wr_en <= 1'b0;
                        state         <= CLEAR_CLOSE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                CLEAR_CLOSE: begin
                    if (clr_addr == LAST) begin
                        bus.clear_done <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        clr_addr      <= clr_addr + 1'b1;
                        bus.mem_addr  <= clr_addr + 1'b1;
                        bus.mem_wr_en <= 1'b1;
                        wcnt          <= '0;
                        state         <= CLEAR_WR;
                    end
                end
                IDLE: begin
                    if (pick_a || pick_b) begin
                        bus.a_gnt     <= pick_a;
                        bus.b_gnt     <= pick_b;
                        bus.busy      <= 1'b1;
                        cur_b         <= pick_b;
                        cur_err       <= sel_err;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_wr_en <= sel_we && !sel_err;
                        wcnt          <= '0;
                        starve_cnt    <= pick_b ? '0 : starve_cnt + SW'(bus.b_req);
                        state         <= sel_we ? WR : RD_ADDR;
                    end
                end
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    bus.rdata  <= cur_err ? 8'h00 : bus.mem_rdata;
                    bus.a_done <= !cur_b;
                    bus.b_done <= cur_b;
                    bus.err    <= cur_err;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                WR: begin
                    if (wcnt == WLAST) begin
                        bus.mem_wr_en <= 1'b0;
                        state         <= WR_CLOSE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                WR_CLOSE: begin
                    bus.a_done <= !cur_b;
                    bus.b_done <= cur_b;
                    bus.err    <= cur_err;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= CLEAR_WR;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_mem_arbiter.sv
// tb_weight_mem_arbiter: directed scoreboard bench for the weight memory arbiter
module tb_weight_mem_arbiter;
    localparam int AW  = 7;
    localparam int SB  = 96;
    localparam int WR1 = 1;

    typedef struct {
        bit         p;
        bit         rd;
        logic [7:0] d;
        bit         e;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   idx, w0, seen;
    exp_t sb[$];
    bit   gq[$];
    logic [7:0] mem [128];
    logic [7:0] mem3 [128];
    logic [7:0] ref_mem [128];
    logic [7:0] rd_q, rd3_q;
    int   clr_cnt [128];
    int   wr_hi = 0;
    int   gnt_clr = 0;

    always #5 clk = ~clk;

    weight_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
    weight_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus3 ();

    weight_mem_arbiter #(.ADDR_WIDTH(AW), .STORAGE_B(SB), .WR_CYCLES(WR1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    weight_mem_arbiter #(.ADDR_WIDTH(AW), .STORAGE_B(SB), .WR_CYCLES(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    // Byte-wide memories with one cycle of read latency
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        rd_q <= mem[bus.mem_addr];
        if (bus3.mem_wr_en) mem3[bus3.mem_addr] <= bus3.mem_wdata;
        rd3_q <= mem3[bus3.mem_addr];
    end
    assign bus.mem_rdata  = rd_q;
    assign bus3.mem_rdata = rd3_q;

    // Record zero-fill pulses per address, total write-enable cycles and grants seen during clear
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) clr_cnt[i] <= 0;
        end else if (bus.mem_wr_en && !bus.clear_done && bus.mem_wdata == 8'h00) begin
            clr_cnt[bus.mem_addr] <= clr_cnt[bus.mem_addr] + 1;
        end
        if (bus.mem_wr_en) wr_hi <= wr_hi + 1;
        if (rst_n && !bus.clear_done && (bus.a_gnt || bus.b_gnt)) gnt_clr <= gnt_clr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One access on the WR_CYCLES=1 instance: expectation queued at drive, popped at done
    task automatic access(input string tag, input bit p, input bit we, input logic [6:0] addr,
                          input logic [7:0] wd);
        exp_t x;
        int lat;
        x.p   = p;
        x.rd  = !we;
        x.e   = int'(addr) >= SB;
        x.d   = (x.e || we) ? 8'h00 : ref_mem[addr];
        x.lat = we ? WR1 + 2 : 3;
        sb.push_back(x);
        if (we && !x.e) ref_mem[addr] = wd;
        if (p) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
        @(negedge clk);
        check({tag, "_gnt"}, {bus.b_gnt, bus.a_gnt}, p ? 2'b10 : 2'b01);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        lat = 1;
        while (!(bus.a_done || bus.b_done) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        x = sb.pop_front();
        check({tag, "_lat"}, lat, x.lat);
        check({tag, "_port"}, {bus.b_done, bus.a_done}, x.p ? 2'b10 : 2'b01);
        check({tag, "_err"}, bus.err, x.e);
        if (x.rd) check({tag, "_rdata"}, bus.rdata, x.d);
    endtask

    initial begin
        {bus.a_req, bus.a_we, bus.a_addr, bus.a_wdata} = '0;
        {bus.b_req, bus.b_we, bus.b_addr, bus.b_wdata} = '0;
        {bus3.a_req, bus3.a_we, bus3.a_addr, bus3.a_wdata} = '0;
        {bus3.b_req, bus3.b_we, bus3.b_addr, bus3.b_wdata} = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.a_gnt, bus.a_done, bus.b_gnt, bus.b_done, bus.rdata, bus.err,
              bus.clear_done, bus.busy, bus.mem_addr, bus.mem_wr_en, bus.mem_wdata}, 0);

        // Zero-fill: requests held during clear must be ignored; the first edge with rst_n high starts it
        rst_n = 1'b1;
        bus.a_req = 1'b1;
        bus.b_req = 1'b1;
        idx = 0;
        while (!bus.clear_done && idx < 400) begin
            @(negedge clk);
            idx++;
            if (idx == 100) begin
                bus.a_req = 1'b0;
                bus.b_req = 1'b0;
            end
        end
        check("clear_latency", idx - 1, SB * (WR1 + 1));
        check("gnt_during_clear", gnt_clr, 0);
        seen = 0;
        for (int i = 0; i < 128; i++) if (clr_cnt[i] != ((i < SB) ? 1 : 0)) seen++;
        check("clear_pulses", seen, 0);
        check("idle_not_busy", bus.busy, 0);

        // Basic A write/read, then B write/read
        w0 = wr_hi;
        access("a_wr9", 1'b0, 1'b1, 7'd9, 8'h5A);
        check("a_wr9_pulses", wr_hi - w0, WR1);
        check("mem9", mem[9], 8'h5A);
        access("a_rd9", 1'b0, 1'b0, 7'd9, 8'h00);
        access("b_wr1", 1'b1, 1'b1, 7'd1, 8'h33);
        access("b_rd1", 1'b1, 1'b0, 7'd1, 8'h00);

        // Both requesting continuously: B forced through after four A grants
        gq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 7'd1;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'd1;
        for (int g = 0; g < 10; g++) begin
            for (int n = 0; n < 10 && !(bus.a_gnt || bus.b_gnt); n++) @(negedge clk);
            check($sformatf("grant%0d", g), {bus.b_gnt, bus.a_gnt}, gq.pop_front() ? 2'b10 : 2'b01);
            if (g == 9) begin
                bus.a_req = 1'b0;
                bus.b_req = 1'b0;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("starve_rdata", bus.rdata, 8'h33);

        // Out-of-range accesses: err with done, zero data, no memory write
        w0 = wr_hi;
        access("b_rd100", 1'b1, 1'b0, 7'd100, 8'h00);
        access("b_wr96", 1'b1, 1'b1, 7'd96, 8'hAB);
        check("oor_no_write", wr_hi - w0, 0);

        // Reset during the WR state of an A write aborts it and restarts the clear
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 7'd3; bus.a_wdata = 8'h77;
        @(negedge clk);
        check("abort_gnt", bus.a_gnt, 1);
        bus.a_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_reset_outputs", {bus.a_gnt, bus.a_done, bus.b_gnt, bus.b_done, bus.rdata, bus.err,
              bus.clear_done, bus.busy, bus.mem_addr, bus.mem_wr_en, bus.mem_wdata}, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.a_done) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_clear_restart", bus.clear_done, 0);
        idx = 0;
        while (!bus.clear_done && idx < 250) begin
            @(negedge clk);
            idx++;
        end
        check("reclear_done", bus.clear_done, 1);
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        access("a_rd3", 1'b0, 1'b0, 7'd3, 8'h00);

        // WR_CYCLES=3 instance: three enable cycles, one close cycle, done five cycles after acceptance
        idx = 0;
        while (!bus3.clear_done && idx < 500) begin
            @(negedge clk);
            idx++;
        end
        check("w3_clear_done", bus3.clear_done, 1);
        bus3.b_req = 1'b1; bus3.b_we = 1'b1; bus3.b_addr = 7'd0; bus3.b_wdata = 8'hFF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("w3_gnt", bus3.b_gnt, 1);
                bus3.b_req = 1'b0;
            end
            check($sformatf("w3_we%0d", c), bus3.mem_wr_en, c <= 3);
            if (c <= 4) check($sformatf("w3_bus%0d", c), {bus3.mem_addr, bus3.mem_wdata}, {7'd0, 8'hFF});
            check($sformatf("w3_done%0d", c), {bus3.b_done, bus3.err}, (c == 5) ? 2'b10 : 2'b00);
        end
        check("mem3_0", mem3[0], 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
